// File: rtl/instr_encoder_pkg.sv
// ISA definitions shared by the instruction encoder: mnemonic codes, opcodes,
// ALU op codes, field bit positions and the instruction format enum.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    M_ADD  = 4'd0,  M_SUB = 4'd1,  M_AND = 4'd2,  M_OR   = 4'd3,
    M_SLL  = 4'd4,  M_SRA = 4'd5,  M_ADDI = 4'd6, M_SW   = 4'd7,
    M_LW   = 4'd8,  M_J   = 4'd9,  M_BNE = 4'd10, M_JAL  = 4'd11,
    M_JR   = 4'd12, M_BLT = 4'd13, M_BEX = 4'd14, M_SETX = 4'd15
  } mnem_e;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_JI, FMT_JII} fmt_e;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  localparam int unsigned OPC_LSB   = 27;
  localparam int unsigned RD_LSB    = 22;
  localparam int unsigned RS_LSB    = 17;
  localparam int unsigned RT_LSB    = 12;
  localparam int unsigned SHAMT_LSB = 7;
  localparam int unsigned ALUOP_LSB = 2;

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational packer from mnemonic + operand fields to a 32-bit
// ISA word, plus a flag for I-type immediates that do not fit in 17 bits.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  mnem_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  shamt_i,
  input  logic [31:0] imm_i,
  input  logic [26:0] target_i,
  output logic [31:0] word_o,
  output logic        imm_oor_o
);

  fmt_e        fmt;
  logic [4:0]  opcode;
  logic [4:0]  aluop;
  logic        shift_op;
  logic        zero_tgt;

  always_comb begin
    fmt      = FMT_R;
    opcode   = OP_RTYPE;
    aluop    = ALU_ADD;
    shift_op = 1'b0;
    zero_tgt = 1'b0;
    unique case (mnem_e'(mnem_i))
      M_ADD:  aluop = ALU_ADD;
      M_SUB:  aluop = ALU_SUB;
      M_AND:  aluop = ALU_AND;
      M_OR:   aluop = ALU_OR;
      M_SLL:  begin aluop = ALU_SLL; shift_op = 1'b1; end
      M_SRA:  begin aluop = ALU_SRA; shift_op = 1'b1; end
      M_ADDI: begin fmt = FMT_I; opcode = OP_ADDI; end
      M_SW:   begin fmt = FMT_I; opcode = OP_SW; end
      M_LW:   begin fmt = FMT_I; opcode = OP_LW; end
      M_BNE:  begin fmt = FMT_I; opcode = OP_BNE; end
      M_BLT:  begin fmt = FMT_I; opcode = OP_BLT; end
      M_J:    begin fmt = FMT_JI; opcode = OP_J; end
      M_JAL:  begin fmt = FMT_JI; opcode = OP_JAL; end
      M_BEX:  begin fmt = FMT_JI; opcode = OP_BEX; zero_tgt = 1'b1; end
      M_SETX: begin fmt = FMT_JI; opcode = OP_SETX; end
      M_JR:   begin fmt = FMT_JII; opcode = OP_JR; end
      default: ;
    endcase
  end

  always_comb begin
    word_o = '0;
    word_o[OPC_LSB +: 5] = opcode;
    unique case (fmt)
      FMT_R: begin
        word_o[RD_LSB +: 5]    = rd_i;
        word_o[RS_LSB +: 5]    = rs_i;
        word_o[RT_LSB +: 5]    = shift_op ? 5'd0 : rt_i;
        word_o[SHAMT_LSB +: 5] = shift_op ? shamt_i : 5'd0;
        word_o[ALUOP_LSB +: 5] = aluop;
      end
      FMT_I: begin
        word_o[RD_LSB +: 5] = rd_i;
        word_o[RS_LSB +: 5] = rs_i;
        word_o[16:0]        = imm_i[16:0];
      end
      FMT_JI:  word_o[26:0] = zero_tgt ? 27'd0 : target_i;
      FMT_JII: word_o[RD_LSB +: 5] = rd_i;
      default: ;
    endcase
  end

  // A value fits in 17-bit two's complement iff bits [31:16] are all equal.
  assign imm_oor_o = (fmt == FMT_I) && !((&imm_i[31:16]) || !(|imm_i[31:16]));

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: handshake front end that packs instructions and writes them
// to imem at an auto-incrementing address. Macro IMM_RANGE_CHECK_EN enables
// rejection of out-of-range I-type immediates with an err pulse.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shamt,
  input  logic [31:0]       imm,
  input  logic [26:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [31:0]       word;
  logic              imm_oor;
  logic              accept, reject;
  logic [ADDR_W:0]   count_inc;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  instr_pack u_pack (
    .mnem_i    (mnem),
    .rd_i      (rd),
    .rs_i      (rs),
    .rt_i      (rt),
    .shamt_i   (shamt),
    .imm_i     (imm),
    .target_i  (target),
    .word_o    (word),
    .imm_oor_o (imm_oor)
  );

  assign in_ready  = ~full_q;
  assign accept    = in_valid & in_ready;
  assign reject    = RANGE_CHK & imm_oor;
  assign count_inc = count_q + 1'b1;

  // Flush dominates: a word offered in the flush cycle is dropped.
  always_comb begin
    we_d    = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    full_d  = full_q;
    if (flush) begin
      count_d = '0;
      full_d  = 1'b0;
    end else if (accept) begin
      if (reject) begin
        err_d = 1'b1;
      end else begin
        we_d   = 1'b1;
        addr_d = count_q[ADDR_W-1:0];
        data_d = word;
        if (count_q != DEPTH_C) count_d = count_inc;
        full_d = (count_inc == DEPTH_C);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_data = data_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4): stimulus pushes expected
// imem writes, a negedge monitor pops and compares each write pulse.
module tb_instr_encoder;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset, flush, in_valid;
  logic              in_ready;
  logic [3:0]        mnem;
  logic [4:0]        rd, rs, rt, shamt;
  logic [31:0]       imm;
  logic [26:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [ADDR_W:0]   count;
  logic              full, err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mnem      (mnem),
    .rd        (rd),
    .rs        (rs),
    .rt        (rt),
    .shamt     (shamt),
    .imm       (imm),
    .target    (target),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] m, input logic [4:0] d, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] sh, input logic [31:0] im,
                      input logic [26:0] tg);
    mnem = m; rd = d; rs = s; rt = t; shamt = sh; imm = im; target = tg;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                   imem_addr, imem_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(imem_addr), e.addr);
          chk("wr_data", imem_data, e.data);
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    mnem = '0; rd = '0; rs = '0; rt = '0; shamt = '0; imm = '0; target = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_data", imem_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    idle(1);

    // addi rd=1 rs=0 imm=5
    push(0, 32'h28400005);
    send(4'd6, 5'd1, 5'd0, 5'd0, 5'd0, 32'd5, 27'd0);
    chk("addi_we", 32'(imem_we), 32'd1);
    chk("addi_count", 32'(count), 32'd1);
    do_flush();
    chk("flush1_count", 32'(count), 32'd0);

    // add then sub back-to-back
    push(0, 32'h00C22000);
    send(4'd0, 5'd3, 5'd1, 5'd2, 5'd0, 32'd0, 27'd0);
    chk("b2b_we0", 32'(imem_we), 32'd1);
    push(1, 32'h00C22004);
    send(4'd1, 5'd3, 5'd1, 5'd2, 5'd0, 32'd0, 27'd0);
    chk("b2b_we1", 32'(imem_we), 32'd1);
    chk("b2b_count", 32'(count), 32'd2);
    do_flush();

    // fill to DEPTH: j, jr, addi -1, sll (rt forced 0)
    push(0, 32'h08000010);
    send(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'h10);
    push(1, 32'h27C00000);
    send(4'd12, 5'd31, 5'd0, 5'd0, 5'd0, 32'd0, 27'd0);
    push(2, 32'h2841FFFF);
    send(4'd6, 5'd1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 27'd0);
    chk("fill_full_early", 32'(full), 32'd0);
    push(3, 32'h00860210);
    send(4'd4, 5'd2, 5'd3, 5'd7, 5'd4, 32'd0, 27'd0);
    chk("full_set", 32'(full), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_we", 32'(imem_we), 32'd1);

    mnem = 4'd0; rd = 5'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("held_count", 32'(count), 32'd4);
      chk("held_ready", 32'(in_ready), 32'd0);
      chk("held_we", 32'(imem_we), 32'd0);
    end
    in_valid = 1'b0;
    do_flush();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_full", 32'(full), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);

    // and (shamt forced 0), bex (target forced 0), setx, sw imm=-4
    push(0, 32'h00443008);
    send(4'd2, 5'd1, 5'd2, 5'd3, 5'd9, 32'd0, 27'd0);
    push(1, 32'hB0000000);
    send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'h123);
    push(2, 32'hA8000005);
    send(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 27'h5);
    push(3, 32'h3887FFFC);
    send(4'd7, 5'd2, 5'd3, 5'd0, 5'd0, 32'hFFFF_FFFC, 27'd0);
    do_flush();

    // bne, then flush together with a valid add
    push(0, 32'h1045FFF8);
    send(4'd10, 5'd1, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFF8, 27'd0);
    chk("bne_count", 32'(count), 32'd1);
    mnem = 4'd0; rd = 5'd3; rs = 5'd1; rt = 5'd2; shamt = 5'd0;
    in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flushacc_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flushacc_count", 32'(count), 32'd0);
    chk("flushacc_we", 32'(imem_we), 32'd0);
    idle(1);

`ifdef IMM_RANGE_CHECK_EN
    send(4'd6, 5'd1, 5'd0, 5'd0, 5'd0, 32'd70000, 27'd0);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_we", 32'(imem_we), 32'd0);
    chk("oor_count", 32'(count), 32'd0);
    idle(1);
    chk("oor_err_pulse", 32'(err), 32'd0);
    push(0, 32'h2840FFFF);
    send(4'd6, 5'd1, 5'd0, 5'd0, 5'd0, 32'd65535, 27'd0);
    chk("inr_count", 32'(count), 32'd1);
    chk("inr_err", 32'(err), 32'd0);
`else
    push(0, 32'h28411170);
    send(4'd6, 5'd1, 5'd0, 5'd0, 5'd0, 32'd70000, 27'd0);
    chk("trunc_err", 32'(err), 32'd0);
    chk("trunc_count", 32'(count), 32'd1);
    push(1, 32'h2840FFFF);
    send(4'd6, 5'd1, 5'd0, 5'd0, 5'd0, 32'd65535, 27'd0);
    chk("inr_count", 32'(count), 32'd2);
`endif
    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // async reset between edges kills the pending pulse
    send(4'd6, 5'd1, 5'd0, 5'd0, 5'd0, 32'd5, 27'd0);
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_we", 32'(imem_we), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_data", imem_data, 32'd0);
    idle(1);
    reset = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
